// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage driving the IF/ID register over an imem req/ack handshake.
// Optional FETCH_COUNT_EN adds fetch_count, a count of instructions delivered to IR_if.
`ifndef WORD
`define WORD 32
`endif
`ifndef ZERO
`define ZERO 32'h0000_0000
`endif
module if_fetch_unit #(
    parameter int WIDTH = `WORD,
    parameter logic [WIDTH-1:0] RESET_PC = `ZERO
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_id,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             imem_ack,
    output logic [WIDTH-1:0] nPC_if,
    output logic [WIDTH-1:0] IR_if,
    output logic             valid_if
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0]      fetch_count
`endif
);
    typedef enum logic [1:0] {IDLE, FETCH, PEND} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] pc, pc_n, pc_inc, sq_addr, sq_addr_n;
    logic [WIDTH-1:0] ir_n, npc_n, pend_ir, pend_ir_n, pend_npc, pend_npc_n;
    logic squash, squash_n, valid_n;
    assign pc_inc = pc + WIDTH'(4);
    assign imem_req = state == FETCH;
    // A squashed request keeps presenting its original address until acked.
    assign imem_addr = squash ? sq_addr : pc;
    always_comb begin
        state_n = state;
        pc_n = pc;
        squash_n = squash;
        sq_addr_n = sq_addr;
        ir_n = IR_if;
        npc_n = nPC_if;
        valid_n = valid_if;
        pend_ir_n = pend_ir;
        pend_npc_n = pend_npc;
        if (branch_taken) begin
            pc_n = branch_target & ~WIDTH'(3);
            state_n = FETCH;
            squash_n = state == FETCH && !imem_ack;
            if (state == FETCH && !imem_ack) sq_addr_n = imem_addr;
            if (!stall_id) begin
                ir_n = '0;
                valid_n = 1'b0;
            end
        end else if (state == IDLE) begin
            state_n = FETCH;
        end else if (state == PEND) begin
            if (!stall_id) begin
                ir_n = pend_ir;
                npc_n = pend_npc;
                valid_n = 1'b1;
                state_n = FETCH;
            end
        end else if (imem_ack && !squash) begin
            pc_n = pc_inc;
            if (stall_id) begin
                pend_ir_n = imem_rdata;
                pend_npc_n = pc_inc;
                state_n = PEND;
            end else begin
                ir_n = imem_rdata;
                npc_n = pc_inc;
                valid_n = 1'b1;
            end
        end else begin
            if (imem_ack) squash_n = 1'b0;
            if (!stall_id) begin
                ir_n = '0;
                valid_n = 1'b0;
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc <= RESET_PC;
            squash <= 1'b0;
            sq_addr <= RESET_PC;
            IR_if <= '0;
            nPC_if <= '0;
            valid_if <= 1'b0;
            pend_ir <= '0;
            pend_npc <= '0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            squash <= squash_n;
            sq_addr <= sq_addr_n;
            IR_if <= ir_n;
            nPC_if <= npc_n;
            valid_if <= valid_n;
            pend_ir <= pend_ir_n;
            pend_npc <= pend_npc_n;
        end
    end
`ifdef FETCH_COUNT_EN
    // valid_if can only rise on an unstalled edge by delivering a word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) fetch_count <= '0;
        else if (valid_n && !stall_id) fetch_count <= fetch_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: scoreboard bench; expected instruction stream is program order from reset/branch targets.
module tb_if_fetch_unit;
    localparam logic [31:0] RPC = 32'h0000_0040;
    logic clk = 1'b0, reset, stall_id, branch_taken, imem_req, imem_ack, valid_if;
    logic [31:0] branch_target, imem_addr, imem_rdata, nPC_if, IR_if;
`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif
    int checks = 0, errors = 0, dcount = 0, total = 0, wcnt = -1, min_lat = 0, max_lat = 0;
    logic [31:0] q[$];
    logic [31:0] next_push, e_addr, p_ir, p_npc;
    logic e_stall, e_br, e_ack, e_req, e_rst = 1'b1, p_valid;

    if_fetch_unit #(.WIDTH(32), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .stall_id(stall_id), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack), .nPC_if(nPC_if), .IR_if(IR_if),
        .valid_if(valid_if)
`ifdef FETCH_COUNT_EN
        , .fetch_count(fetch_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[31:16]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic topup();
        while (q.size() < 16) begin
            q.push_back(next_push);
            next_push = next_push + 32'd4;
        end
    endtask

    task automatic flush(input logic [31:0] a);
        q.delete();
        next_push = a;
        topup();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        topup();
    endtask

    task automatic br(input logic [31:0] t, input logic st);
        branch_taken = 1'b1;
        branch_target = t;
        stall_id = st;
        step();
        branch_taken = 1'b0;
        flush(t & ~32'd3);
    endtask

    task automatic wait_req(input logic [31:0] a);
        for (int i = 0; i < 40 && !(imem_req && imem_addr == a); i++) step();
        chk("wait_req", {31'b0, imem_req}, 32'd1);
        chk("wait_req_addr", imem_addr, a);
    endtask

    // Monitor: checks the result of the last edge, then acts as memory, then samples for the next edge.
    always @(negedge clk) begin
        if (reset) dcount = 0;
        else if (!e_rst) begin
            if (e_stall) begin
                chk("hold_ir", IR_if, p_ir);
                chk("hold_npc", nPC_if, p_npc);
                chk("hold_valid", {31'b0, valid_if}, {31'b0, p_valid});
            end else if (valid_if) begin
                if (q.size() == 0) chk("queue_empty", 32'd0, 32'd1);
                else begin
                    chk("ir", IR_if, mem(q[0]));
                    chk("npc", nPC_if, q[0] + 32'd4);
                    void'(q.pop_front());
                end
                dcount++;
                total++;
            end else chk("bubble_ir", IR_if, 32'd0);
            if (e_br && !e_stall) chk("branch_bubble", {31'b0, valid_if}, 32'd0);
            if (e_req && !e_ack && !e_stall && !e_br) chk("wait_bubble", {31'b0, valid_if}, 32'd0);
            if (e_req && !e_ack) begin
                chk("req_hold", {31'b0, imem_req}, 32'd1);
                chk("addr_hold", imem_addr, e_addr);
            end
`ifdef FETCH_COUNT_EN
            chk("fetch_count", fetch_count, dcount);
`endif
        end
        if (reset || !imem_req) begin
            imem_ack = 1'b0;
            imem_rdata = $urandom;
            wcnt = -1;
        end else begin
            if (wcnt < 0) wcnt = $urandom_range(max_lat, min_lat);
            imem_ack = wcnt == 0;
            imem_rdata = imem_ack ? mem(imem_addr) : $urandom;
            wcnt = imem_ack ? -1 : wcnt - 1;
        end
        e_stall = stall_id;
        e_br = branch_taken;
        e_ack = imem_ack;
        e_req = imem_req;
        e_addr = imem_addr;
        e_rst = reset;
        p_ir = IR_if;
        p_npc = nPC_if;
        p_valid = valid_if;
    end

    initial begin
        reset = 1'b1;
        stall_id = 1'b0;
        branch_taken = 1'b0;
        branch_target = '0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_ir", IR_if, 32'd0);
        chk("rst_npc", nPC_if, 32'd0);
        chk("rst_valid", {31'b0, valid_if}, 32'd0);
        flush(RPC);
        step();
        step();
        reset = 1'b0;
        repeat (8) step();
        min_lat = 2;
        max_lat = 2;
        repeat (14) step();
        min_lat = 0;
        max_lat = 0;
        repeat (2) step();
        stall_id = 1'b1;
        repeat (4) step();
        stall_id = 1'b0;
        repeat (4) step();
        min_lat = 3;
        max_lat = 3;
        br(32'h0000_0050, 1'b0);
        wait_req(32'h0000_0050);
        br(32'h0000_0103, 1'b0);
        wait_req(32'h0000_0100);
        repeat (12) step();
        min_lat = 0;
        max_lat = 0;
        repeat (2) step();
        br(32'h0000_0200, 1'b1);
        repeat (2) step();
        stall_id = 1'b0;
        repeat (5) step();
        br(32'hFFFF_FFF8, 1'b0);
        repeat (6) step();
        max_lat = 3;
        for (int i = 0; i < 1500; i++) begin
            stall_id = $urandom_range(0, 4) == 0;
            if ($urandom_range(0, 19) == 0) br($urandom, stall_id);
            else step();
        end
        stall_id = 1'b0;
        min_lat = 3;
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
        chk("mid_rst_addr", imem_addr, RPC);
        chk("mid_rst_ir", IR_if, 32'd0);
        chk("mid_rst_npc", nPC_if, 32'd0);
        chk("mid_rst_valid", {31'b0, valid_if}, 32'd0);
`ifdef FETCH_COUNT_EN
        chk("mid_rst_count", fetch_count, 32'd0);
`endif
        flush(RPC);
        step();
        step();
        reset = 1'b0;
        min_lat = 0;
        max_lat = 0;
        repeat (4) step();
        chk("restart_npc", nPC_if, RPC + 32'd12);
        chk("restart_valid", {31'b0, valid_if}, 32'd1);
`ifdef FETCH_COUNT_EN
        chk("restart_count", fetch_count, 32'd3);
`endif
        chk("progress", {31'b0, total >= 300}, 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
